seg7_scan_driver: RTL and testbench

Multiplexed multi-digit 7-segment display driver for the counter LED board.
- Holds a DIGITS-wide packed-nibble value and time-multiplexes one digit at a time onto a shared segment bus with a one-hot digit select.
- Adds per-digit decimal points, an optional hex mode, leading-zero blanking, anti-ghost dead time and tear-free updates.
- Sits between the counter core and the FPGA pins. Supersedes the single-digit combinational BCD decoder.

---
 rtl/seg7_pkg.sv | 49 ++++
 rtl/seg7_decode.sv | 35 +++
 rtl/seg7_scan_driver.sv | 145 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared glyph constants and helpers for the multiplexed 7-segment display driver.
// Glyph bit order is g..a (bit 6 = g, bit 0 = a), active-high.
package seg7_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_A     = 7'h77;
  localparam logic [6:0] GLYPH_B     = 7'h7C;
  localparam logic [6:0] GLYPH_C     = 7'h39;
  localparam logic [6:0] GLYPH_D     = 7'h5E;
  localparam logic [6:0] GLYPH_E     = 7'h79;
  localparam logic [6:0] GLYPH_F     = 7'h71;
  localparam logic [6:0] GLYPH_DASH  = 7'h40;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  // Marks every digit that is zero and has only zeros above it among the
  // first 'digits' nibbles. Digit 0 is never marked so a zero value still
  // shows a single "0".
  function automatic logic [MAX_DIGITS-1:0] lzMask(
    input logic [4*MAX_DIGITS-1:0] nibbles,
    input int                      digits
  );
    logic [MAX_DIGITS-1:0] mask;
    logic                  stillZero;
    mask      = '0;
    stillZero = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
      if (i < digits) begin
        if (stillZero && (nibbles[4*i +: 4] == 4'h0)) begin
          mask[i] = 1'b1;
        end else begin
          stillZero = 1'b0;
        end
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-glyph decoder. Values A-F either show as hex
// letters or collapse to a dash when hex display is switched off.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       hexEn_i,
  output logic [6:0] glyph_o
);

  // Table lookup; the letter rows pick between hex glyph and dash.
  always_comb begin
    glyph_o = GLYPH_BLANK;
    case (nibble_i)
      4'h0: glyph_o = GLYPH_0;
      4'h1: glyph_o = GLYPH_1;
      4'h2: glyph_o = GLYPH_2;
      4'h3: glyph_o = GLYPH_3;
      4'h4: glyph_o = GLYPH_4;
      4'h5: glyph_o = GLYPH_5;
      4'h6: glyph_o = GLYPH_6;
      4'h7: glyph_o = GLYPH_7;
      4'h8: glyph_o = GLYPH_8;
      4'h9: glyph_o = GLYPH_9;
      4'hA: glyph_o = hexEn_i ? GLYPH_A : GLYPH_DASH;
      4'hB: glyph_o = hexEn_i ? GLYPH_B : GLYPH_DASH;
      4'hC: glyph_o = hexEn_i ? GLYPH_C : GLYPH_DASH;
      4'hD: glyph_o = hexEn_i ? GLYPH_D : GLYPH_DASH;
      4'hE: glyph_o = hexEn_i ? GLYPH_E : GLYPH_DASH;
      4'hF: glyph_o = hexEn_i ? GLYPH_F : GLYPH_DASH;
      default: glyph_o = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed multi-digit 7-segment scan driver. A shadow register takes
// new values at any time; the displayed (active) copy only changes at a
// frame boundary so a frame never mixes old and new digits. Each digit slot
// starts with a few dead cycles with everything off to stop ghosting.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  hex_en,
  input  logic                  blank_lz,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [4*DIGITS-1:0] shadowValue_q;
  logic [DIGITS-1:0]   shadowDp_q;
  logic [4*DIGITS-1:0] activeValue_q;
  logic [DIGITS-1:0]   activeDp_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   digSel_q, digSel_d;
  logic                frameDone_q, frameDone_d;
  logic                restart_q;

  logic                    slotEnd;
  logic                    lastDigit;
  logic                    takeActive;
  logic                    inDead;
  logic [3:0]              selNibble;
  logic                    selDp;
  logic                    selBlank;
  logic [MAX_DIGITS-1:0]   lzBits;
  logic [6:0]              decodedGlyph;
  logic [6:0]              shownGlyph;

  seg7_decode u_decode (
    .nibble_i (selNibble),
    .hexEn_i  (hex_en),
    .glyph_o  (decodedGlyph)
  );

  // Prescaler/digit-index stepping and detection of slot and frame edges.
  // A restart (first enabled cycle after a disable or reset) acts as a
  // frame boundary for the active register but never pulses frame_done.
  always_comb begin
    slotEnd     = (cnt_q == CNT_W'(PRESCALE - 1));
    lastDigit   = (idx_q == IDX_W'(DIGITS - 1));
    takeActive  = en && (restart_q || (slotEnd && lastDigit));
    frameDone_d = en && !restart_q && slotEnd && lastDigit;
    cnt_d       = '0;
    idx_d       = '0;
    if (en) begin
      if (slotEnd) begin
        cnt_d = '0;
        idx_d = lastDigit ? '0 : idx_q + IDX_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
      end
    end
  end

  // Pick the nibble, decimal point and leading-zero flag of the current digit.
  always_comb begin
    lzBits    = lzMask(32'(activeValue_q), DIGITS);
    selNibble = 4'h0;
    selDp     = 1'b0;
    selBlank  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        selNibble = activeValue_q[4*i +: 4];
        selDp     = activeDp_q[i];
      end
    end
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (int'(idx_q) == i) begin
        selBlank = lzBits[i];
      end
    end
  end

  // Next output word: dark during dead time or when disabled, otherwise the
  // selected digit's glyph with its decimal point.
  always_comb begin
    inDead     = (cnt_q < CNT_W'(BLANK_CYCLES));
    shownGlyph = (blank_lz && selBlank) ? GLYPH_BLANK : decodedGlyph;
    seg_d      = 8'h00;
    digSel_d   = '0;
    if (en && !inDead) begin
      seg_d    = {selDp, shownGlyph};
      digSel_d = DIGITS'(1) << idx_q;
    end
  end

  // All state plus registered outputs; a load on a boundary edge goes
  // straight into the active copy so it is not delayed a whole frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadowValue_q <= '0;
      shadowDp_q    <= '0;
      activeValue_q <= '0;
      activeDp_q    <= '0;
      cnt_q         <= '0;
      idx_q         <= '0;
      seg_q         <= 8'h00;
      digSel_q      <= '0;
      frameDone_q   <= 1'b0;
      restart_q     <= 1'b1;
    end else begin
      if (load) begin
        shadowValue_q <= value;
        shadowDp_q    <= dp;
      end
      if (takeActive) begin
        activeValue_q <= load ? value : shadowValue_q;
        activeDp_q    <= load ? dp    : shadowDp_q;
      end
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      digSel_q    <= digSel_d;
      frameDone_q <= frameDone_d;
      restart_q   <= !en;
    end
  end

  assign seg        = seg_q;
  assign dig_sel    = digSel_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed testbench for seg7_scan_driver: a 4-digit instance with a short
// prescaler for scan/decode/tearing checks and a 1-digit instance for the
// single-digit corner case.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;

  logic        en4, load4, hexEn4, blankLz4;
  logic [15:0] value4;
  logic [3:0]  dp4;
  logic [7:0]  seg4;
  logic [3:0]  digSel4;
  logic        frameDone4;

  logic        en1, load1, hexEn1, blankLz1;
  logic [3:0]  value1;
  logic [0:0]  dp1;
  logic [7:0]  seg1;
  logic [0:0]  digSel1;
  logic        frameDone1;

  int checkCount = 0;
  int errorCount = 0;
  int cycleN     = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(1)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .en         (en4),
    .load       (load4),
    .value      (value4),
    .dp         (dp4),
    .hex_en     (hexEn4),
    .blank_lz   (blankLz4),
    .seg        (seg4),
    .dig_sel    (digSel4),
    .frame_done (frameDone4)
  );

  seg7_scan_driver #(.DIGITS(1), .PRESCALE(2), .BLANK_CYCLES(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .en         (en1),
    .load       (load1),
    .value      (value1),
    .dp         (dp1),
    .hex_en     (hexEn1),
    .blank_lz   (blankLz1),
    .seg        (seg1),
    .dig_sel    (digSel1),
    .frame_done (frameDone1)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cycleN);
    end
  endtask

  // Advance one clock; outputs are sampled at the falling edge.
  task automatic tick();
    @(negedge clk);
    cycleN++;
  endtask

  task automatic advanceTo(input int target);
    while (cycleN < target) tick();
  endtask

  // Reference glyph table written out by hand from the decode table.
  function automatic logic [6:0] glyphOf(input logic [3:0] n, input logic hx);
    case (n)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return hx ? 7'h77 : 7'h40;
      4'hB: return hx ? 7'h7C : 7'h40;
      4'hC: return hx ? 7'h39 : 7'h40;
      4'hD: return hx ? 7'h5E : 7'h40;
      4'hE: return hx ? 7'h79 : 7'h40;
      default: return hx ? 7'h71 : 7'h40;
    endcase
  endfunction

  // Drop enable for one cycle, then re-enable with a load so the restart
  // boundary takes the new value straight into the display. Called at a
  // falling edge; returns just after the first (dead) enabled cycle.
  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] d, input logic hx, input logic blz);
    en4   = 1'b0;
    load4 = 1'b0;
    @(negedge clk);
    en4      = 1'b1;
    load4    = 1'b1;
    value4   = v;
    dp4      = d;
    hexEn4   = hx;
    blankLz4 = blz;
    cycleN   = 0;
    tick();
    load4 = 1'b0;
  endtask

  // Digit i is lit on cycles 2+4i .. 4+4i after a restart; check the first.
  task automatic checkFrame(input logic [31:0] expSegs, input string tag);
    for (int i = 0; i < 4; i++) begin
      advanceTo(2 + 4*i);
      checkOutput($sformatf("%s seg d%0d", tag, i), {24'h0, seg4}, {24'h0, expSegs[8*i +: 8]});
      checkOutput($sformatf("%s dig_sel d%0d", tag, i), {28'h0, digSel4}, 32'(1) << i);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] sweep [4];
    logic [31:0] expSegs;
    int          p;

    sweep[0] = 16'h3210;
    sweep[1] = 16'h7654;
    sweep[2] = 16'hBA98;
    sweep[3] = 16'hFEDC;

    rst = 1'b1;
    en4 = 1'b1; load4 = 1'b0; value4 = 16'h0; dp4 = 4'h0; hexEn4 = 1'b1; blankLz4 = 1'b0;
    en1 = 1'b1; load1 = 1'b1; value1 = 4'h8; dp1 = 1'b1; hexEn1 = 1'b0; blankLz1 = 1'b0;

    #1;
    checkOutput("reset seg", {24'h0, seg4}, 32'h0);
    checkOutput("reset dig_sel", {28'h0, digSel4}, 32'h0);
    checkOutput("reset frame_done", {31'h0, frameDone4}, 32'h0);
    checkOutput("reset d1 seg", {24'h0, seg1}, 32'h0);

    repeat (2) @(negedge clk);
    rst    = 1'b0;
    cycleN = 0;

    // Free-running scan of a zero value, two frames plus one cycle.
    for (int n = 1; n <= 33; n++) begin
      tick();
      p = (n - 1) % 16;
      checkOutput("scan dig_sel", {28'h0, digSel4}, (p % 4 == 0) ? 32'h0 : (32'h1 << (p / 4)));
      checkOutput("scan seg", {24'h0, seg4}, (p % 4 == 0) ? 32'h0 : 32'h3F);
      checkOutput("scan frame_done", {31'h0, frameDone4}, (n % 16 == 0) ? 32'h1 : 32'h0);
      if (n <= 8) begin
        checkOutput("d1 dig_sel", {31'h0, digSel1}, (n % 2 == 0) ? 32'h1 : 32'h0);
        checkOutput("d1 frame_done", {31'h0, frameDone1}, (n % 2 == 0) ? 32'h1 : 32'h0);
        checkOutput("d1 seg", {24'h0, seg1}, (n % 2 == 0) ? 32'hFF : 32'h0);
      end
    end

    // Asynchronous reset in the middle of a lit slot.
    tick();
    checkOutput("pre-reset dig_sel", {28'h0, digSel4}, 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("async reset seg", {24'h0, seg4}, 32'h0);
    checkOutput("async reset dig_sel", {28'h0, digSel4}, 32'h0);
    checkOutput("async reset frame_done", {31'h0, frameDone4}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Decode sweep in hex and dash modes, with varying decimal points.
    for (int hx = 1; hx >= 0; hx--) begin
      for (int s = 0; s < 4; s++) begin
        for (int i = 0; i < 4; i++) begin
          expSegs[8*i +: 8] = {s[i], glyphOf(sweep[s][4*i +: 4], hx[0])};
        end
        applyStimulus(sweep[s], s[3:0], hx[0], 1'b0);
        checkFrame(expSegs, $sformatf("decode %h hex%0d", sweep[s], hx));
      end
    end

    // Leading-zero suppression.
    applyStimulus(16'h0042, 4'b0100, 1'b1, 1'b1);
    checkFrame({8'h00, 8'h80, 8'h66, 8'h5B}, "lz 0042");
    applyStimulus(16'h0000, 4'b0000, 1'b1, 1'b1);
    checkFrame({8'h00, 8'h00, 8'h00, 8'h3F}, "lz 0000");

    // Mid-frame load must not tear; a load on the boundary edge shows next frame.
    applyStimulus(16'h2222, 4'b0000, 1'b1, 1'b0);
    advanceTo(3);
    load4  = 1'b1;
    value4 = 16'h1111;
    tick();
    load4 = 1'b0;
    advanceTo(6);  checkOutput("tear d1", {24'h0, seg4}, 32'h5B);
    advanceTo(10); checkOutput("tear d2", {24'h0, seg4}, 32'h5B);
    advanceTo(14); checkOutput("tear d3", {24'h0, seg4}, 32'h5B);
    advanceTo(16); checkOutput("tear frame_done", {31'h0, frameDone4}, 32'h1);
    advanceTo(18); checkOutput("next frame d0", {24'h0, seg4}, 32'h06);
    advanceTo(22); checkOutput("next frame d1", {24'h0, seg4}, 32'h06);
    advanceTo(30); checkOutput("next frame d3", {24'h0, seg4}, 32'h06);
    advanceTo(31);
    load4  = 1'b1;
    value4 = 16'h3333;
    tick();
    load4 = 1'b0;
    checkOutput("boundary frame_done", {31'h0, frameDone4}, 32'h1);
    advanceTo(34); checkOutput("boundary load d0", {24'h0, seg4}, 32'h4F);
    checkOutput("boundary load dig_sel", {28'h0, digSel4}, 32'h1);
    advanceTo(46); checkOutput("boundary load d3", {24'h0, seg4}, 32'h4F);

    // Enable dropped for five cycles mid-frame, shadow still loads.
    applyStimulus(16'h5555, 4'b0000, 1'b1, 1'b0);
    advanceTo(6);
    checkOutput("en pre seg", {24'h0, seg4}, 32'h6D);
    checkOutput("en pre dig_sel", {28'h0, digSel4}, 32'h2);
    en4    = 1'b0;
    load4  = 1'b1;
    value4 = 16'h7777;
    for (int k = 0; k < 5; k++) begin
      tick();
      load4 = 1'b0;
      checkOutput("en off seg", {24'h0, seg4}, 32'h0);
      checkOutput("en off dig_sel", {28'h0, digSel4}, 32'h0);
      checkOutput("en off frame_done", {31'h0, frameDone4}, 32'h0);
    end
    en4 = 1'b1;
    tick();
    checkOutput("re-en dead dig_sel", {28'h0, digSel4}, 32'h0);
    checkOutput("re-en frame_done", {31'h0, frameDone4}, 32'h0);
    tick();
    checkOutput("re-en slot0 dig_sel", {28'h0, digSel4}, 32'h1);
    checkOutput("re-en slot0 seg", {24'h0, seg4}, 32'h07);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
